lsu_mem_seq: RTL

- Load/store access sequencer between the core's load/store request and the byte-enable data memory port.
- Directly upstream of the load-extraction stage (mem_receiver); it produces that stage's read_data, Addr2Lsb and func3 inputs.
- Converts one request into one or two word-aligned memory transactions, with byte enables, store-data lane steering and load-data realignment.
- Reports completion and errors on a single-cycle response pulse.

---
 rtl/lsu_mem_seq.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_seq.sv
// Load/store sequencer: turns one core request into one or two word-aligned memory beats.
// Optional macro LSU_MISALIGN_SPLIT_EN enables two-beat handling of word-crossing accesses.
module lsu_mem_seq #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_func3,
    input  logic [31:0]       req_wdata,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rx_read_data,
    output logic [1:0]        rx_addr_lsb,
    output logic [2:0]        rx_func3
);
    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t            state, state_nx;
    logic              we_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        func3_q;
    logic [31:0]       wdata_q, d0_q;
    logic [7:0]        wait_cnt;
    logic              accept, cap0, cap1, tmo, ld_done, req_bad;
    logic [1:0]        off, size;
    logic              crosses, split, realign, beat1;
    logic [7:0]        be_wide;
    logic [5:0]        sh;
    logic [31:0]       wrot, d0_src, merged, drot;

    function automatic logic [3:0] mask_f(input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic crosses_f(input logic [1:0] sz, input logic [1:0] o);
        logic [2:0] nb;
        nb = (sz == 2'b00) ? 3'd1 : (sz == 2'b01) ? 3'd2 : 3'd4;
        return ({1'b0, o} + nb) > 3'd4;
    endfunction

    assign off     = addr_q[1:0];
    assign size    = func3_q[1:0];
    assign crosses = crosses_f(size, off);
    assign realign = (size == 2'b01 && off[0]) || (size == 2'b10 && off != 2'b00);
    assign be_wide = {4'b0000, mask_f(size)} << off;
    assign sh      = {1'b0, off, 3'b000};
    assign wrot    = (wdata_q << sh) | (wdata_q >> (6'd32 - sh));

`ifdef LSU_MISALIGN_SPLIT_EN
    assign split   = crosses;
    assign beat1   = (state == REQ1);
    assign req_bad = (req_func3[1:0] == 2'b11);
`else
    assign split   = 1'b0;
    assign beat1   = 1'b0;
    assign req_bad = (req_func3[1:0] == 2'b11) || crosses_f(req_func3[1:0], req_addr[1:0]);
`endif

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        cap0     = 1'b0;
        cap1     = 1'b0;
        tmo      = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                accept   = 1'b1;
                state_nx = req_bad ? RESP : REQ0;
            end
            REQ0: if (mem_gnt) state_nx = !we_q ? WAIT0 : (split ? REQ1 : RESP);
            WAIT0: begin
                if (mem_rvalid) begin
                    cap0     = 1'b1;
                    state_nx = split ? REQ1 : RESP;
                end else if (wait_cnt == WAIT_LAST) begin
                    tmo      = 1'b1;
                    state_nx = RESP;
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            REQ1: if (mem_gnt) state_nx = we_q ? RESP : WAIT1;
            WAIT1: begin
                if (mem_rvalid) begin
                    cap1     = 1'b1;
                    state_nx = RESP;
                end else if (wait_cnt == WAIT_LAST) begin
                    tmo      = 1'b1;
                    state_nx = RESP;
                end
            end
`endif
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Merge happens on the edge entering RESP, so the final beat is taken straight off mem_rdata.
    always_comb begin
        d0_src = cap0 ? mem_rdata : d0_q;
        merged = d0_src;
        for (int i = 0; i < 4; i++)
            if (crosses && i < int'(off)) merged[8*i +: 8] = mem_rdata[8*i +: 8];
    end
    assign drot    = (merged >> sh) | (merged << (6'd32 - sh));
    assign ld_done = !we_q && ((cap0 && !split) || cap1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            func3_q      <= '0;
            wdata_q      <= '0;
            d0_q         <= '0;
            wait_cnt     <= '0;
            rx_read_data <= '0;
            rx_addr_lsb  <= '0;
            rx_func3     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                func3_q <= req_func3;
                wdata_q <= req_wdata;
                err_q   <= req_bad;
            end else if (tmo) begin
                err_q <= 1'b1;
            end
            if (state == WAIT0 || state == WAIT1) wait_cnt <= wait_cnt + 8'd1;
            else                                  wait_cnt <= '0;
            if (cap0) d0_q <= mem_rdata;
            if (ld_done) begin
                rx_read_data <= realign ? drot : d0_src;
                rx_addr_lsb  <= realign ? 2'b00 : off;
                rx_func3     <= func3_q;
            end
        end
    end

    always_comb begin
        req_ready = (state == IDLE);
        mem_req   = (state == REQ0) || beat1;
        mem_addr  = '0;
        mem_be    = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (mem_req) begin
            mem_addr  = {addr_q[ADDR_W-1:2], 2'b00} + {{(ADDR_W-3){1'b0}}, beat1, 2'b00};
            mem_be    = beat1 ? be_wide[7:4] : be_wide[3:0];
            mem_we    = we_q;
            mem_wdata = we_q ? wrot : '0;
        end
        rsp_valid = (state == RESP);
        rsp_err   = rsp_valid && err_q;
    end
endmodule
